// File: rtl/layer_compositor_pkg.sv
`default_nettype none
// ============================================================================
// layer_compositor_pkg : fade state encoding, fade level range, pixel widths
// Rev 1.0
// ============================================================================
package layer_compositor_pkg;

  typedef enum logic [1:0] {
    ST_FULL       = 2'd0,
    ST_FADING_OUT = 2'd1,
    ST_DARK       = 2'd2,
    ST_FADING_IN  = 2'd3
  } fade_state_t;

  localparam int LEVEL_MAX       = 16;
  localparam int LEVEL_W         = 5;
  localparam int DEFAULT_COLOR_W = 12;
  localparam int DEFAULT_CH_W    = DEFAULT_COLOR_W / 3;

endpackage
`default_nettype wire

// File: rtl/layer_compositor_fade_controller.sv
`default_nettype none
// ============================================================================
// fade_controller : frame-stepped fade level (0..16) with reversible fading
// Rev 1.0
// ============================================================================
module fade_controller
  import layer_compositor_pkg::*;
#(
  parameter int FRAMES_PER_STEP = 4
) (
  input  logic               clk,
  input  logic               hard_reset_n,
  input  logic               frame_pulse,
  input  logic               fade_start,
  input  logic               fade_dir,
  output logic [LEVEL_W-1:0] level,
  output logic               busy
);

  localparam int               CNT_W    = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);
  localparam logic [LEVEL_W-1:0] LVL_TOP = LEVEL_W'(LEVEL_MAX);

  fade_state_t        r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [LEVEL_W-1:0] r_level;
  logic               r_busy;

  always_ff @(posedge clk) begin
    if (!hard_reset_n) begin
      r_state <= ST_FULL;
      r_cnt   <= '0;
      r_level <= LVL_TOP;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_FULL: begin
          if (fade_start && fade_dir) begin
            r_state <= ST_FADING_OUT;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_DARK: begin
          if (fade_start && !fade_dir) begin
            r_state <= ST_FADING_IN;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          // A start request wins over a coincident frame boundary: no step that cycle.
          if (fade_start) begin
            r_state <= fade_dir ? ST_FADING_OUT : ST_FADING_IN;
            r_cnt   <= '0;
          end else if (frame_pulse) begin
            if (r_cnt == CNT_LAST) begin
              r_cnt <= '0;
              if (r_state == ST_FADING_OUT) begin
                r_level <= r_level - 1'b1;
                if (r_level == LEVEL_W'(1)) begin
                  r_state <= ST_DARK;
                  r_busy  <= 1'b0;
                end
              end else begin
                r_level <= r_level + 1'b1;
                if (r_level == LVL_TOP - 1'b1) begin
                  r_state <= ST_FULL;
                  r_busy  <= 1'b0;
                end
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign level = r_level;
  assign busy  = r_busy;

endmodule
`default_nettype wire

// File: rtl/layer_compositor.sv
`default_nettype none
// ============================================================================
// layer_compositor : priority layer select, colour key, global fade, 2-tick sync delay
// Rev 1.0
// ============================================================================
module layer_compositor
  import layer_compositor_pkg::*;
#(
  parameter int                 NUM_LAYERS      = 10,
  parameter int                 COLOR_W         = DEFAULT_COLOR_W,
  parameter logic [COLOR_W-1:0] TRANSPARENT_KEY = COLOR_W'(12'hF0F),
  parameter int                 FRAMES_PER_STEP = 4,
  localparam int                IDX_W           = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                          clk,
  input  logic                          hard_reset_n,
  input  logic                          pixel_tick,
  input  logic                          video_on,
  input  logic                          hsync_in,
  input  logic                          vsync_in,
  input  logic [NUM_LAYERS-1:0]         layer_on,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb,
  input  logic [NUM_LAYERS-1:0]         layer_en,
  input  logic [NUM_LAYERS-1:0]         key_en,
  input  logic [COLOR_W-1:0]            bg_rgb,
  input  logic                          fade_start,
  input  logic                          fade_dir,
  output logic [COLOR_W-1:0]            rgb_out,
  output logic                          hsync_out,
  output logic                          vsync_out,
  output logic [IDX_W-1:0]              top_layer,
  output logic                          top_valid,
  output logic                          fade_busy
);

  localparam int CH_W = COLOR_W / 3;

  logic [NUM_LAYERS-1:0] w_visible;
  logic [COLOR_W-1:0]    w_sel_rgb;
  logic [IDX_W-1:0]      w_sel_idx;
  logic                  w_sel_valid;
  logic [LEVEL_W-1:0]    w_level;
  logic                  w_frame_pulse;
  logic [COLOR_W-1:0]    w_faded;

  logic [COLOR_W-1:0]    r_s1_rgb;
  logic [IDX_W-1:0]      r_s1_idx;
  logic                  r_s1_valid;
  logic                  r_s1_hs;
  logic                  r_s1_vs;
  logic                  r_s1_vs_prev;

  for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_vis
    assign w_visible[gi] = layer_on[gi] & layer_en[gi] &
                           ~(key_en[gi] & (layer_rgb[gi*COLOR_W +: COLOR_W] == TRANSPARENT_KEY));
  end

  // Scan from the lowest priority upward so the lowest visible index is left standing.
  always_comb begin
    w_sel_rgb   = bg_rgb;
    w_sel_idx   = '0;
    w_sel_valid = 1'b0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (w_visible[i]) begin
        w_sel_rgb   = layer_rgb[i*COLOR_W +: COLOR_W];
        w_sel_idx   = IDX_W'(i);
        w_sel_valid = 1'b1;
      end
    end
    if (!video_on) begin
      w_sel_rgb   = '0;
      w_sel_idx   = '0;
      w_sel_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!hard_reset_n) begin
      r_s1_rgb     <= '0;
      r_s1_idx     <= '0;
      r_s1_valid   <= 1'b0;
      r_s1_hs      <= 1'b0;
      r_s1_vs      <= 1'b0;
      r_s1_vs_prev <= 1'b0;
    end else if (pixel_tick) begin
      r_s1_rgb     <= w_sel_rgb;
      r_s1_idx     <= w_sel_idx;
      r_s1_valid   <= w_sel_valid;
      r_s1_hs      <= hsync_in;
      r_s1_vs      <= vsync_in;
      r_s1_vs_prev <= r_s1_vs;
    end
  end

  // One-cycle frame marker on the tick where the stage-1 vsync rise is first seen.
  assign w_frame_pulse = pixel_tick & r_s1_vs & ~r_s1_vs_prev;

  fade_controller #(
    .FRAMES_PER_STEP (FRAMES_PER_STEP)
  ) u_fade (
    .clk          (clk),
    .hard_reset_n (hard_reset_n),
    .frame_pulse  (w_frame_pulse),
    .fade_start   (fade_start),
    .fade_dir     (fade_dir),
    .level        (w_level),
    .busy         (fade_busy)
  );

  for (genvar gc = 0; gc < 3; gc++) begin : g_ch
    logic [CH_W+4:0] w_prod;
    assign w_prod = (CH_W+5)'(r_s1_rgb[gc*CH_W +: CH_W]) * (CH_W+5)'(w_level);
    assign w_faded[gc*CH_W +: CH_W] = CH_W'(w_prod >> 4);
  end

  always_ff @(posedge clk) begin
    if (!hard_reset_n) begin
      rgb_out   <= '0;
      top_layer <= '0;
      top_valid <= 1'b0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else if (pixel_tick) begin
      rgb_out   <= w_faded;
      top_layer <= r_s1_idx;
      top_valid <= r_s1_valid;
      hsync_out <= r_s1_hs;
      vsync_out <= r_s1_vs;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_layer_compositor.sv
`default_nettype none
// ============================================================================
// tb_layer_compositor : scoreboard bench for priority, colour key, sync delay and fade
// Rev 1.0
// ============================================================================
module tb_layer_compositor;

  localparam int NL = 10;
  localparam int CW = 12;

  logic            clk = 1'b0;
  logic            hard_reset_n, pixel_tick, video_on, hsync_in, vsync_in;
  logic            fade_start, fade_dir;
  logic [NL-1:0]   layer_on, layer_en, key_en;
  logic [NL*CW-1:0] layer_rgb;
  logic [CW-1:0]   bg_rgb, rgb_out;
  logic            hsync_out, vsync_out, top_valid, fade_busy;
  logic [3:0]      top_layer;

  always #5 clk = ~clk;

  layer_compositor #(
    .NUM_LAYERS      (NL),
    .COLOR_W         (CW),
    .TRANSPARENT_KEY (12'hF0F),
    .FRAMES_PER_STEP (4)
  ) dut (
    .clk          (clk),
    .hard_reset_n (hard_reset_n),
    .pixel_tick   (pixel_tick),
    .video_on     (video_on),
    .hsync_in     (hsync_in),
    .vsync_in     (vsync_in),
    .layer_on     (layer_on),
    .layer_rgb    (layer_rgb),
    .layer_en     (layer_en),
    .key_en       (key_en),
    .bg_rgb       (bg_rgb),
    .fade_start   (fade_start),
    .fade_dir     (fade_dir),
    .rgb_out      (rgb_out),
    .hsync_out    (hsync_out),
    .vsync_out    (vsync_out),
    .top_layer    (top_layer),
    .top_valid    (top_valid),
    .fade_busy    (fade_busy)
  );

  typedef struct {
    int         due;
    int         tag;
    bit         chk;
    logic [11:0] rgb;
    logic [3:0] idx;
    logic       valid;
    logic       hs;
    logic       vs;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   mon_ticks = 0;
  int   checks    = 0;
  int   errors    = 0;
  int   tag_cnt   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Output monitor: each tick edge retires the entry issued one tick earlier.
  initial begin
    forever begin
      @(posedge clk);
      if (pixel_tick === 1'b1 && hard_reset_n === 1'b1) begin
        mon_ticks++;
        #1;
        while (sb.size() > 0 && sb[0].due <= mon_ticks) begin
          m_e = sb.pop_front();
          if (m_e.chk) begin
            check($sformatf("sb%0d_align", m_e.tag), 32'(m_e.due), 32'(mon_ticks));
            check($sformatf("sb%0d_pix", m_e.tag),
                  32'({rgb_out, top_valid, hsync_out, vsync_out}),
                  32'({m_e.rgb, m_e.valid, m_e.hs, m_e.vs}));
            if (m_e.valid)
              check($sformatf("sb%0d_idx", m_e.tag), 32'(top_layer), 32'(m_e.idx));
          end
        end
      end
    end
  end

  task automatic tick(input bit chk, input logic [11:0] er, input logic [3:0] ei, input logic ev);
    exp_t e;
    e.due   = mon_ticks + 2;
    e.tag   = tag_cnt;
    e.chk   = chk;
    e.rgb   = er;
    e.idx   = ei;
    e.valid = ev;
    e.hs    = hsync_in;
    e.vs    = vsync_in;
    if (chk) tag_cnt++;
    sb.push_back(e);
    pixel_tick = 1'b1;
    @(negedge clk);
    pixel_tick = 1'b0;
    fade_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle_tick();
    tick(1'b0, 12'h000, 4'd0, 1'b0);
  endtask

  task automatic frames(input int n);
    for (int f = 0; f < n; f++) begin
      vsync_in = 1'b1;
      idle_tick();
      vsync_in = 1'b0;
      repeat (3) idle_tick();
    end
  endtask

  // Fade-in request placed on the tick that carries the frame boundary.
  task automatic frame_collide();
    vsync_in = 1'b1;
    idle_tick();
    vsync_in   = 1'b0;
    fade_start = 1'b1;
    fade_dir   = 1'b0;
    idle_tick();
    repeat (2) idle_tick();
  endtask

  task automatic probe(input logic [11:0] er);
    tick(1'b1, er, 4'd0, 1'b0);
    idle_tick();
  endtask

  task automatic pulse_start(input logic d);
    fade_start = 1'b1;
    fade_dir   = d;
    @(negedge clk);
    fade_start = 1'b0;
  endtask

  task automatic set_layer(input int i, input logic [11:0] c);
    layer_rgb[i*CW +: CW] = c;
  endtask

  int pend;

  initial begin
    hard_reset_n = 1'b0;
    pixel_tick   = 1'b0;
    video_on     = 1'b0;
    hsync_in     = 1'b0;
    vsync_in     = 1'b0;
    fade_start   = 1'b0;
    fade_dir     = 1'b0;
    layer_on     = '0;
    layer_en     = '1;
    key_en       = '0;
    layer_rgb    = '0;
    bg_rgb       = 12'h0A5;
    repeat (3) @(negedge clk);
    check("reset_out", 32'({rgb_out, top_layer, top_valid, hsync_out, vsync_out, fade_busy}), 32'd0);
    hard_reset_n = 1'b1;
    @(negedge clk);

    // Priority, enable mask, colour key, blanking
    video_on = 1'b1;
    set_layer(0, 12'h123);
    set_layer(3, 12'h456);
    layer_on = 10'b00_0000_1001;
    tick(1'b1, 12'h123, 4'd0, 1'b1);
    layer_en[0] = 1'b0;
    tick(1'b1, 12'h456, 4'd3, 1'b1);
    layer_en = '1;
    layer_on = 10'b00_0000_0100;
    set_layer(2, 12'hF0F);
    key_en[2] = 1'b1;
    tick(1'b1, 12'h0A5, 4'd0, 1'b0);
    key_en = '0;
    tick(1'b1, 12'hF0F, 4'd2, 1'b1);
    layer_on = 10'b10_0000_0000;
    set_layer(9, 12'hF0E);
    key_en = '1;
    tick(1'b1, 12'hF0E, 4'd9, 1'b1);
    set_layer(0, 12'hF0F);
    set_layer(1, 12'h789);
    layer_on = '1;
    key_en   = 10'b00_0000_0001;
    tick(1'b1, 12'h789, 4'd1, 1'b1);
    video_on = 1'b0;
    tick(1'b1, 12'h000, 4'd0, 1'b0);
    video_on = 1'b1;
    layer_en = '0;
    tick(1'b1, 12'h0A5, 4'd0, 1'b0);
    layer_en = '1;
    key_en   = '0;

    // Sync alignment through the scoreboard
    layer_on = '0;
    hsync_in = 1'b1;
    tick(1'b1, 12'h0A5, 4'd0, 1'b0);
    hsync_in = 1'b0;
    tick(1'b1, 12'h0A5, 4'd0, 1'b0);
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    tick(1'b1, 12'h0A5, 4'd0, 1'b0);
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    tick(1'b1, 12'h0A5, 4'd0, 1'b0);

    // Freeze while pixel_tick is low
    layer_on = 10'b00_0000_1000;
    hsync_in = 1'b1;
    tick(1'b1, 12'h456, 4'd3, 1'b1);
    layer_on = '0;
    hsync_in = 1'b0;
    idle_tick();
    video_on = 1'b0;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    bg_rgb   = 12'h000;
    repeat (6) @(negedge clk);
    check("freeze", 32'({rgb_out, top_layer, top_valid, hsync_out, vsync_out}),
          32'({12'h456, 4'd3, 1'b1, 1'b1, 1'b0}));
    video_on = 1'b1;
    hsync_in = 1'b0;
    vsync_in = 1'b0;

    // Fade tests use a white background pixel
    bg_rgb = 12'hFFF;
    idle_tick();
    idle_tick();

    pulse_start(1'b0);
    check("fadein_in_full_busy", 32'(fade_busy), 32'd0);
    frames(4);
    probe(12'hFFF);

    pulse_start(1'b1);
    check("fadeout_busy", 32'(fade_busy), 32'd1);
    frames(3);
    probe(12'hFFF);
    frames(1);
    probe(12'hEEE);
    frames(60);
    probe(12'h000);
    check("dark_busy", 32'(fade_busy), 32'd0);

    pulse_start(1'b0);
    check("fadein_busy", 32'(fade_busy), 32'd1);
    frames(16);
    probe(12'h333);
    frames(48);
    probe(12'hFFF);
    check("full_busy", 32'(fade_busy), 32'd0);

    // Reverse at level 10 on a boundary that would otherwise step
    pulse_start(1'b1);
    frames(27);
    probe(12'h999);
    frame_collide();
    check("reverse_busy", 32'(fade_busy), 32'd1);
    frames(3);
    probe(12'h999);
    frames(1);
    probe(12'hAAA);
    frames(20);
    probe(12'hFFF);
    check("climb_busy", 32'(fade_busy), 32'd0);

    // Reset mid-fade at level 7
    pulse_start(1'b1);
    frames(36);
    probe(12'h666);
    check("midfade_busy", 32'(fade_busy), 32'd1);
    hard_reset_n = 1'b0;
    hsync_in     = 1'b1;
    @(negedge clk);
    check("midfade_reset", 32'({rgb_out, top_layer, top_valid, hsync_out, vsync_out, fade_busy}), 32'd0);
    hard_reset_n = 1'b1;
    hsync_in     = 1'b0;
    sb.delete();
    probe(12'hFFF);

    repeat (3) idle_tick();
    pend = 0;
    foreach (sb[i]) if (sb[i].chk) pend++;
    check("drain", 32'(pend), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/layer_compositor.md
Name: layer_compositor

Overview:
- Parametrised successor to the fixed top-level RGB priority mux in the VGA game designs.
- Takes NUM_LAYERS sprite/overlay layers plus a background. Selects the highest-priority visible pixel, with per-layer enable and colour-key transparency.
- Applies a frame-stepped global fade (for game-over/start transitions) and delays hsync/vsync to stay aligned with the 2-tick pixel pipeline.
- Sits between the sprite units and the VGA DAC pins.

Parameters:
- NUM_LAYERS, 10, number of overlay layers; index 0 has highest priority.
- COLOR_W, 12, pixel width (RGB 4:4:4). Must be divisible by 3; CH_W = COLOR_W/3.
- TRANSPARENT_KEY, 12'hF0F, colour treated as transparent on key-enabled layers.
- FRAMES_PER_STEP, 4, frames per fade level step (>=1).

Ports:
- clk  in  1  system pixel-domain clock
- hard_reset_n  in  1  synchronous active-low reset
- pixel_tick  in  1  pixel enable from vga_sync; pipeline advances only when high
- video_on  in  1  active-video flag aligned with layer inputs
- hsync_in  in  1  horizontal sync aligned with layer inputs
- vsync_in  in  1  vertical sync aligned with layer inputs
- layer_on  in  NUM_LAYERS  per-layer pixel-hit flags
- layer_rgb  in  NUM_LAYERS*COLOR_W  packed layer colours; layer i at bits [i*COLOR_W +: COLOR_W]
- layer_en  in  NUM_LAYERS  per-layer enable mask (game-state gating)
- key_en  in  NUM_LAYERS  per-layer colour-key enable
- bg_rgb  in  COLOR_W  background colour
- fade_start  in  1  single-cycle fade request
- fade_dir  in  1  1 = fade out, 0 = fade in; sampled with fade_start
- rgb_out  out  COLOR_W  composited, faded pixel to DAC
- hsync_out  out  1  hsync delayed 2 ticks
- vsync_out  out  1  vsync delayed 2 ticks
- top_layer  out  clog2(NUM_LAYERS)  index of the winning layer for the current output pixel
- top_valid  out  1  1 when a layer won; 0 when background or blanking
- fade_busy  out  1  high in FADING_OUT or FADING_IN

Behaviour:
- Reset (hard_reset_n=0 at clk edge): rgb_out=0, hsync_out=0, vsync_out=0, top_layer=0, top_valid=0, fade_busy=0, level=16, fade state FULL, frame counter=0, pipeline regs=0.
- A layer i is visible when layer_on[i] & layer_en[i] & ~(key_en[i] & layer_rgb[i]==TRANSPARENT_KEY).
- Stage 1 (on pixel_tick):
  - Lowest visible index wins.
  - If none is visible, bg_rgb is selected and top_valid=0.
  - If video_on=0, colour=0 and top_valid=0, regardless of layers.
  - Registers colour, index, valid, hsync, vsync and vsync_prev.
- Stage 2 (on pixel_tick): each CH_W channel is replaced by (ch*level)>>4, computed in CH_W+5 bits and then truncated. level=16 passes colour unchanged; level=0 gives black. Index, valid and syncs pass straight through.
- Latency: exactly 2 pixel_ticks from input to every output. Outputs hold between ticks; there is no change on non-tick cycles.
- Frame boundary: the stage-1 vsync register transitions 0->1 on a pixel_tick. This is a single-cycle internal pulse.
- Fade FSM states: FULL (level 16), FADING_OUT, DARK (level 0), FADING_IN.
  - FULL + fade_start & fade_dir=1 -> FADING_OUT.
  - DARK + fade_start & fade_dir=0 -> FADING_IN.
  - Start requests toward the current static state are ignored: fade-in in FULL, fade-out in DARK.
  - fade_start while FADING reverses direction from the current level with no jump, and clears the frame counter.
  - While FADING, each frame boundary increments the frame counter. At FRAMES_PER_STEP-1 the counter clears and level moves by 1 toward the target.
  - level reaching 0 -> DARK; level reaching 16 -> FULL. level never leaves 0..16.
  - fade_start coincident with a frame boundary: the start is taken, the counter clears, and no level step occurs that cycle.
- Level changes apply to stage 2 immediately; mid-frame steps are allowed only at the frame boundary, so no tearing occurs.
- Reset mid-fade returns to FULL/level 16 on the next clk edge.

Decomposition:
- Shared package holds:
  - fade state encoding (FULL, FADING_OUT, DARK, FADING_IN);
  - LEVEL_MAX=16 and LEVEL_W=5;
  - the colour-width constants (COLOR_W, CH_W).
- One sub-module, fade_controller: FSM, frame counter and level register; output level[4:0] and busy.
- Priority select and the channel multiply remain in layer_compositor.

Test Plan:
- Priority: layers 0,3 on, both enabled, video_on=1, level 16 -> after 2 ticks rgb_out=layer_rgb[0], top_layer=0, top_valid=1. Clear layer_en[0] -> layer 3 colour, top_layer=3.
- Colour key: layer 2 only, rgb 12'hF0F, key_en[2]=1 -> rgb_out=bg_rgb, top_valid=0. With key_en[2]=0 -> 12'hF0F, top_layer=2.
- Blanking/latency: video_on=0 with layers on -> rgb_out=0. Toggle hsync_in -> hsync_out follows exactly 2 ticks later. Holding pixel_tick low freezes all outputs.
- Fade out: FRAMES_PER_STEP=4, fade_start/dir=1, pixel 12'hFFF -> level 15 after 4 frames gives rgb_out=12'hEEE (15*15>>4=14); DARK after 64 frames, rgb_out=0, fade_busy drops.
- Reversal and collision: fade out to level 10, pulse fade_start/dir=0 on a frame-boundary cycle -> no step that cycle, counter=0, level climbs 10->16. Fade-in request in FULL is ignored and fade_busy stays 0.
- Reset mid-fade: hard_reset_n=0 for one clk while FADING_OUT at level 7 -> next edge level 16, FULL, all outputs 0.
